gol_gen_ctrl: RTL

Generation scheduler for the Game of Life core. It sits between the VGA timing generator and the life engine. It turns frame-start pulses into generation requests at a programmable frame period and supports run, pause, single-step, seed and clear commands. It swaps the double-buffered display frame only on a frame boundary, so the display never tears.

---
 rtl/gol_gen_ctrl_pkg.sv | 19 +
 rtl/gol_frame_div.sv | 40 ++++
 rtl/gol_gen_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/gol_gen_ctrl_pkg.sv
// Shared types and constants for the Game of Life generation scheduler.
package gol_gen_ctrl_pkg;

  typedef enum logic [1:0] {
    GEN   = 2'd0,
    SEED  = 2'd1,
    CLEAR = 2'd2
  } eng_mode_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    BUSY      = 2'd2,
    SWAP_WAIT = 2'd3
  } gen_state_t;

  localparam int DEFAULT_GEN_PERIOD = 60;

endpackage

// File: rtl/gol_frame_div.sv
// Frame divider: counts frame_start pulses while running and flags the frame
// on which a generation period has elapsed.
module gol_frame_div #(
  parameter int PERIOD_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                frame_start,
  input  logic                run_en,
  input  logic [PERIOD_W-1:0] period,
  output logic                elapse
);

  logic [PERIOD_W-1:0] fcnt_q, fcnt_d;
  logic [PERIOD_W-1:0] eff_period;
  logic [PERIOD_W-1:0] last_cnt;

  always_comb begin
    eff_period = (period == '0) ? PERIOD_W'(1) : period;
    last_cnt   = eff_period - PERIOD_W'(1);
    // >= rather than == so that lowering period mid-count elapses at once
    elapse     = run_en && frame_start && (fcnt_q >= last_cnt);

    fcnt_d = fcnt_q;
    if (!run_en) begin
      fcnt_d = '0;
    end else if (frame_start) begin
      fcnt_d = elapse ? '0 : fcnt_q + PERIOD_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt_q <= '0;
    end else begin
      fcnt_q <= fcnt_d;
    end
  end

endmodule

// File: rtl/gol_gen_ctrl.sv
// Generation scheduler: turns frame-period elapses and host commands into
// engine passes and swaps the display buffer only on a frame boundary.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | no pass in flight; launches on clear/seed/elapse/step
// START     | eng_start pulse to the engine for one cycle
// BUSY      | engine running, waiting for eng_done
// SWAP_WAIT | pass finished, waiting for frame_start to swap buffers
module gol_gen_ctrl
  import gol_gen_ctrl_pkg::*;
#(
  parameter int PERIOD_W  = 8,
  parameter int GEN_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 frame_start,
  input  logic                 run_en,
  input  logic [PERIOD_W-1:0]  period,
  input  logic                 step_req,
  input  logic                 seed_req,
  input  logic                 clear_req,
  output logic                 eng_start,
  output logic [1:0]           eng_mode,
  input  logic                 eng_done,
  output logic                 buf_sel,
  output logic                 busy,
  output logic [GEN_CNT_W-1:0] gen_count,
  output logic                 overrun
);

  gen_state_t           state_q, state_d;
  eng_mode_t            mode_q, mode_d;
  logic                 buf_sel_q, buf_sel_d;
  logic [GEN_CNT_W-1:0] gen_count_q, gen_count_d;
  logic                 clr_pend_q, clr_pend_d;
  logic                 seed_pend_q, seed_pend_d;
  logic                 overrun_q, overrun_d;

  logic      elapse;
  logic      clr_any;
  logic      seed_any;
  logic      can_launch;
  logic      launch;
  eng_mode_t launch_mode;

  gol_frame_div #(
    .PERIOD_W (PERIOD_W)
  ) u_frame_div (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .run_en      (run_en),
    .period      (period),
    .elapse      (elapse)
  );

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    buf_sel_d   = buf_sel_q;
    gen_count_d = gen_count_q;
    can_launch  = 1'b0;
    launch      = 1'b0;
    launch_mode = GEN;

    clr_any  = clr_pend_q | clear_req;
    seed_any = seed_pend_q | seed_req;

    case (state_q)
      IDLE: begin
        can_launch = 1'b1;
      end
      START: begin
        state_d = BUSY;
      end
      BUSY: begin
        if (eng_done) begin
          state_d = SWAP_WAIT;
        end
      end
      SWAP_WAIT: begin
        if (frame_start) begin
          buf_sel_d   = ~buf_sel_q;
          gen_count_d = (mode_q == GEN) ? gen_count_q + GEN_CNT_W'(1) : '0;
          can_launch  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Step only counts from a true IDLE; a swap frame relaunches on elapse or pending work
    if (can_launch) begin
      if (clr_any) begin
        launch      = 1'b1;
        launch_mode = CLEAR;
      end else if (seed_any) begin
        launch      = 1'b1;
        launch_mode = SEED;
      end else if (elapse) begin
        launch      = 1'b1;
        launch_mode = GEN;
      end else if ((state_q == IDLE) && step_req && !run_en) begin
        launch      = 1'b1;
        launch_mode = GEN;
      end
    end

    if (launch) begin
      state_d = START;
      mode_d  = launch_mode;
    end

    clr_pend_d  = clr_any  && !(launch && (launch_mode == CLEAR));
    seed_pend_d = seed_any && !(launch && (launch_mode == SEED));

    // Elapse on a swap frame is consumed by the relaunch, so only START/BUSY drop it
    overrun_d = elapse && ((state_q == START) || (state_q == BUSY));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mode_q      <= GEN;
      buf_sel_q   <= 1'b0;
      gen_count_q <= '0;
      clr_pend_q  <= 1'b0;
      seed_pend_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      buf_sel_q   <= buf_sel_d;
      gen_count_q <= gen_count_d;
      clr_pend_q  <= clr_pend_d;
      seed_pend_q <= seed_pend_d;
      overrun_q   <= overrun_d;
    end
  end

  assign eng_start = (state_q == START);
  assign eng_mode  = mode_q;
  assign busy      = (state_q != IDLE);
  assign buf_sel   = buf_sel_q;
  assign gen_count = gen_count_q;
  assign overrun   = overrun_q;

endmodule
